// File: rtl/lfsr_rr_server.sv
// lfsr_rr_server: one 8-bit maximal-length LFSR shared among NUM_REQ requesters.
// A round-robin arbiter picks one requester per cycle. The winner gets the current
// LFSR value and the LFSR steps, so every draw goes to exactly one requester.
// After reset or a seed load, the generator takes WARMUP steps before it serves requests.
module lfsr_rr_server #(
   parameter int         NUM_REQ = 4,
   parameter logic [7:0] SEED    = 8'h01,
   parameter int         WARMUP  = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               seed_load,
   input  logic [7:0]         seed_val,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic               rnd_valid,
   output logic [7:0]         rnd_data,
   output logic               busy
);

   typedef enum logic {ST_WARMUP, ST_SERVE} state_t;

   localparam int              IDX_W    = $clog2(NUM_REQ);
   localparam logic [7:0]      SEED_FIX = (SEED == 8'h00) ? 8'h01 : SEED;
   localparam logic [3:0]      WLAST    = (WARMUP == 0) ? 4'd0 : 4'(WARMUP - 1);
   localparam logic [IDX_W-1:0] RR_INIT = IDX_W'(NUM_REQ - 1);

   // Polynomial taps 8,6,5,4. The LFSR never reaches the all-zero state.
   function automatic logic [7:0] lfsr_next(input logic [7:0] q);
      return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
   endfunction

   // An all-zero seed would lock up the LFSR, so it is replaced by 8'h01.
   function automatic logic [7:0] fix_seed(input logic [7:0] s);
      return (s == 8'h00) ? 8'h01 : s;
   endfunction

   state_t             state_q, state_d;
   logic [7:0]         lfsr_q, lfsr_d;
   logic [3:0]         wcnt_q, wcnt_d;
   logic [IDX_W-1:0]   rr_q, rr_d;
   logic [NUM_REQ-1:0] gnt_d;
   logic [7:0]         data_d;

   logic               win_found;
   logic [IDX_W-1:0]   win_idx;
   int                 cand;

   // Round-robin search: the first set req bit, scanning upward from rr_q+1 and wrapping.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = int'(rr_q) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(cand);
         end
      end
   end

   // Next-state logic. A seed load has priority; otherwise warm-up stepping or serving.
   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      wcnt_d  = wcnt_q;
      rr_d    = rr_q;
      gnt_d   = '0;
      data_d  = rnd_data;
      if (seed_load) begin
         lfsr_d  = fix_seed(seed_val);
         wcnt_d  = 4'd0;
         state_d = ST_WARMUP;
      end else begin
         unique case (state_q)
            ST_WARMUP: begin
               if (WARMUP == 0) begin
                  state_d = ST_SERVE;
               end else begin
                  lfsr_d = lfsr_next(lfsr_q);
                  wcnt_d = wcnt_q + 4'd1;
                  if (wcnt_q == WLAST) begin
                     wcnt_d  = 4'd0;
                     state_d = ST_SERVE;
                  end
               end
            end
            ST_SERVE: begin
               if (win_found) begin
                  gnt_d[win_idx] = 1'b1;
                  data_d         = lfsr_q;
                  lfsr_d         = lfsr_next(lfsr_q);
                  rr_d           = win_idx;
               end
            end
            default: state_d = ST_WARMUP;
         endcase
      end
   end

   // State and output registers. Reset clears the grant immediately, so no value is delivered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: asynchronous reset reaches every register here, so outputs are known as soon as rst_n falls.
         state_q   <= ST_WARMUP;
         lfsr_q    <= SEED_FIX;
         wcnt_q    <= 4'd0;
         rr_q      <= RR_INIT;
         gnt       <= '0;
         rnd_valid <= 1'b0;
         rnd_data  <= 8'h00;
      end else begin
         // NOTE: non-blocking assignments make all registers update together from the values before the edge.
         state_q   <= state_d;
         lfsr_q    <= lfsr_d;
         wcnt_q    <= wcnt_d;
         rr_q      <= rr_d;
         gnt       <= gnt_d;
         rnd_valid <= |gnt_d;
         rnd_data  <= data_d;
      end
   end

   // busy comes directly from the state register.
   assign busy = (state_q == ST_WARMUP);

endmodule
